// File: rtl/vga_sync.sv
// VGA timing generator: free-running h/v counters with registered sync, visible-area
// flag and line/frame start strobes. Geometry and sync polarity are set per mode.
module vga_sync #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned COORD_W    = 10
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               visible_o,
    output logic               line_start_o,
    output logic               frame_start_o
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if ((longint'(H_TOTAL) > (longint'(1) << COORD_W)) ||
        (longint'(V_TOTAL) > (longint'(1) << COORD_W))) begin : g_width_check
        $error("vga_sync: COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS_END  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS_END  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic               hsync_q, vsync_q, visible_q, line_start_q, frame_start_q;
    logic               hs_act, vs_act, vis;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_comb begin
        hs_act = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
        vs_act = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
        vis    = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    end

    // Outputs show the decode of the counter value the counters are leaving this edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            h_q           <= '0;
            v_q           <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (enable_i) begin
            h_q           <= h_d;
            v_q           <= v_d;
            x_q           <= h_q;
            y_q           <= v_q;
            hsync_q       <= hs_act ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_q       <= vs_act ? V_SYNC_POL : ~V_SYNC_POL;
            visible_q     <= vis;
            line_start_q  <= (h_q == '0);
            frame_start_q <= (h_q == '0) && (v_q == '0);
        end else begin
            // Strobes must not repeat while stalled on the same position.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign visible_o     = visible_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default 640x480 instance for line, stall and reset
// behaviour, plus an active-high 1056-wide, 12-line instance for full-frame periods.
module tb_vga_sync;

    logic clk = 1'b0;
    logic rst, en_a, en_b;

    always #5 clk = ~clk;

    logic [9:0]  x_a, y_a;
    logic        hs_a, vs_a, vis_a, ls_a, fs_a;
    logic [10:0] x_b, y_b;
    logic        hs_b, vs_b, vis_b, ls_b, fs_b;

    vga_sync u_dut_a (
        .clk_i        (clk),
        .reset_i      (rst),
        .enable_i     (en_a),
        .x_o          (x_a),
        .y_o          (y_a),
        .hsync_o      (hs_a),
        .vsync_o      (vs_a),
        .visible_o    (vis_a),
        .line_start_o (ls_a),
        .frame_start_o(fs_a)
    );

    vga_sync #(
        .H_VISIBLE (800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
        .V_VISIBLE (6),   .V_FRONT(1),  .V_SYNC(2),   .V_BACK(3),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .COORD_W(11)
    ) u_dut_b (
        .clk_i        (clk),
        .reset_i      (rst),
        .enable_i     (en_b),
        .x_o          (x_b),
        .y_o          (y_b),
        .hsync_o      (hs_b),
        .vsync_o      (vs_b),
        .visible_o    (vis_b),
        .line_start_o (ls_b),
        .frame_start_o(fs_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int x, input int y, input int hs,
                           input int vs, input int vis, input int ls, input int fs);
        check({tag, ".x"},   int'(x_a),   x);
        check({tag, ".y"},   int'(y_a),   y);
        check({tag, ".hs"},  int'(hs_a),  hs);
        check({tag, ".vs"},  int'(vs_a),  vs);
        check({tag, ".vis"}, int'(vis_a), vis);
        check({tag, ".ls"},  int'(ls_a),  ls);
        check({tag, ".fs"},  int'(fs_a),  fs);
    endtask

    initial begin
        int vis_fall, hs_first, hs_last, hs_cnt, ls_cnt, fs_cnt, vs_cnt, seq_err;
        int hold_err, vs_first_y, vis_cnt, y_pre, x_pre;

        rst  = 1'b1;
        en_a = 1'b1;
        en_b = 1'b0;
        step();
        step();
        check_a("reset", 0, 0, 1, 1, 0, 0, 0);
        check("reset_b.hs", int'(hs_b), 0);
        check("reset_b.vs", int'(vs_b), 0);

        rst = 1'b0;
        step();
        check_a("first", 0, 0, 1, 1, 1, 1, 1);

        // One line of the default mode
        vis_fall = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; ls_cnt = 0; seq_err = 0;
        for (int i = 1; i < 800; i++) begin
            step();
            if (int'(x_a) != i || y_a != 10'd0) seq_err++;
            if (!vis_a && vis_fall < 0) vis_fall = int'(x_a);
            if (!hs_a) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
            if (ls_a || fs_a) ls_cnt++;
        end
        check("line.x_seq",    seq_err,  0);
        check("line.vis_fall", vis_fall, 640);
        check("line.hs_first", hs_first, 656);
        check("line.hs_last",  hs_last,  751);
        check("line.hs_cnt",   hs_cnt,   96);
        check("line.strobes",  ls_cnt,   0);
        step();
        check_a("wrap_line", 0, 1, 1, 1, 1, 1, 0);

        fs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            step();
            if (fs_a) fs_cnt++;
            if (!vs_a) vs_cnt++;
            if (ls_a) ls_cnt++;
        end
        check("lines12.fs",  fs_cnt, 0);
        check("lines12.vs",  vs_cnt, 0);
        check("lines12.ls",  ls_cnt, 2);
        check_a("line3", 0, 3, 1, 1, 1, 1, 0);

        // Stall on the line-start cycle
        en_a = 1'b0;
        hold_err = 0; ls_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (x_a != 10'd0 || y_a != 10'd3 || !vis_a || !hs_a || !vs_a) hold_err++;
            if (ls_a || fs_a) ls_cnt++;
        end
        check("stall.hold",    hold_err, 0);
        check("stall.strobes", ls_cnt,   0);
        en_a = 1'b1;
        step();
        check_a("resume", 1, 3, 1, 1, 1, 0, 0);

        repeat (299) step();
        check_a("pre_reset", 300, 3, 1, 1, 1, 0, 0);

        // Asynchronous reset, checked before the next clock edge
        rst = 1'b1;
        #2;
        check_a("async_reset", 0, 0, 1, 1, 0, 0, 0);
        step();
        rst  = 1'b0;
        en_b = 1'b1;
        step();
        check_a("restart", 0, 0, 1, 1, 1, 1, 1);
        check("b_first.x",   int'(x_b),   0);
        check("b_first.fs",  int'(fs_b),  1);
        check("b_first.vis", int'(vis_b), 1);
        check("b_first.hs",  int'(hs_b),  0);
        check("b_first.vs",  int'(vs_b),  0);

        // Full frame of the active-high instance (1056 x 12)
        hs_cnt = 0; hs_first = -1; hs_last = -1; vs_cnt = 0; vs_first_y = -1;
        vis_cnt = 0; fs_cnt = 0; ls_cnt = 0; y_pre = -1; x_pre = -1;
        for (int i = 1; i <= 1056 * 12; i++) begin
            step();
            if (hs_b) begin
                hs_cnt++;
                if (y_b == 11'd0) begin
                    if (hs_first < 0) hs_first = int'(x_b);
                    hs_last = int'(x_b);
                end
            end
            if (vs_b) begin
                vs_cnt++;
                if (vs_first_y < 0) vs_first_y = int'(y_b);
            end
            if (vis_b) vis_cnt++;
            if (fs_b) fs_cnt++;
            if (ls_b) ls_cnt++;
            if (i == 1056 * 12 - 1) begin
                y_pre = int'(y_b);
                x_pre = int'(x_b);
            end
        end
        check("frame_b.hs_cnt",   hs_cnt,     1536);
        check("frame_b.hs_first", hs_first,   840);
        check("frame_b.hs_last",  hs_last,    967);
        check("frame_b.vs_cnt",   vs_cnt,     2112);
        check("frame_b.vs_y",     vs_first_y, 7);
        check("frame_b.vis_cnt",  vis_cnt,    4800);
        check("frame_b.fs_cnt",   fs_cnt,     1);
        check("frame_b.ls_cnt",   ls_cnt,     12);
        check("frame_b.x_pre",    x_pre,      1055);
        check("frame_b.y_pre",    y_pre,      11);
        check("frame_b.wrap_x",   int'(x_b),  0);
        check("frame_b.wrap_y",   int'(y_b),  0);
        check("frame_b.wrap_fs",  int'(fs_b), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
